// File: rtl/sdf_pkg.sv
// sdf_pkg: shared FSM state type and width helpers
// for the single-path delay-feedback FFT stage control.
package sdf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } sdf_state_t;

    localparam int DEF_N   = 64;
    localparam int DEF_S   = 64;
    localparam int DEF_LAT = 1;
    localparam int DEF_LN  = $clog2(DEF_N);

    // width of a counter holding 0..v-1, never below 1
    function automatic int log2w(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sdf_pipe_dly.sv
// sdf_pipe_dly: DEPTH-stage register chain, async reset,
// synchronous clear to discard in-flight entries.
module sdf_pipe_dly #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [DEPTH];

    // shift chain; clear drops everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: SDF FFT stage sequencer (muxes, valid, counters).
// Define SDF_CTRL_TWIDDLE_EN to add the tw_addr twiddle ROM address.
module sdf_stage_ctrl
    import sdf_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int S   = DEF_S,
    parameter int LAT = DEF_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_in,
    output logic                  sel_fb,
    output logic                  out_sel,
    output logic                  out_en,
    output logic [log2w(N)-1:0]   out_cnt,
    output logic                  frame_done,
    output logic                  err,
    output logic                  busy
`ifdef SDF_CTRL_TWIDDLE_EN
    ,
    output logic [log2w(N)-2:0]   tw_addr
`endif
);

    localparam int LN   = log2w(N);
    localparam int LS   = log2w(S);
    localparam int HALF = S / 2;
    localparam int FLN  = HALF + LAT;
    localparam int FW   = log2w(FLN) + 1;

    sdf_state_t     state;
    sdf_state_t     state_nx;
    logic [LN-1:0]  in_cnt;
    logic [FW-1:0]  fl_cnt;
    logic           fl_done;
    logic           start;
    logic           st_d;
    logic           run_q;
    logic [1:0]     pd_d;
    logic [1:0]     pd_q;

    // input sample index, restarts whenever the input goes idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         in_cnt <= '0;
        else if (enable_in) in_cnt <= in_cnt + LN'(1);
        else                in_cnt <= '0;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    assign fl_done = (fl_cnt == FW'(FLN - 1));

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (enable_in) state_nx = FILL;
            FILL: begin
                if (!enable_in)  state_nx = IDLE;
                else if (sel_fb) state_nx = RUN;
            end
            RUN: begin
                if (!enable_in)
                    state_nx = (in_cnt == '0) ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (enable_in)    state_nx = FILL;
                else if (fl_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // decoded outputs
    always_comb begin
        sel_fb     = enable_in & in_cnt[LS-1];
        busy       = (state != IDLE);
        err        = ((state == FILL) || (state == RUN))
                     && !enable_in && (in_cnt != '0);
        frame_done = out_en && (out_cnt == LN'(N - 1));
    end

    // first feedback sample of each frame launches the output window
    assign start = sel_fb && (in_cnt == LN'(HALF));
    assign pd_d  = {sel_fb, start};

    sdf_pipe_dly #(
        .DEPTH (LAT),
        .WIDTH (2)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (err),
        .d     (pd_d),
        .q     (pd_q)
    );

    assign out_sel = pd_q[1];
    assign st_d    = pd_q[0];
    assign out_en  = st_d | run_q;

    // hold valid through the frame; a new start overlaps the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= out_en && !err
                             && (out_cnt != LN'(N - 1));
    end

    // output index, parked at 0 outside the valid window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              out_cnt <= '0;
        else if (out_en && !err) out_cnt <= out_cnt + LN'(1);
        else                     out_cnt <= '0;
    end

    // drain timer, only runs while staying in FLUSH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  fl_cnt <= '0;
        else if ((state == FLUSH)
                 && (state_nx == FLUSH)) fl_cnt <= fl_cnt + FW'(1);
        else                         fl_cnt <= '0;
    end

`ifdef SDF_CTRL_TWIDDLE_EN
    localparam int TW = LN - 1;

    logic [TW-1:0] tw_m;

    // twiddle index for delay-line outputs, k mod S/2 scaled by N/S
    always_comb begin
        tw_m    = out_cnt[TW-1:0] & TW'(HALF - 1);
        tw_addr = '0;
        if (out_en && !out_sel) tw_addr = tw_m * TW'(N / S);
    end
`endif

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl: directed checks of two stage configurations
// (N=S=16 LAT=1 and N=16 S=2 LAT=3) sharing clock, reset, enable.
module tb_sdf_stage_ctrl;

    logic       clk;
    logic       rst_n;
    logic       enable_in;

    logic       a_sel_fb, a_out_sel, a_out_en;
    logic [3:0] a_out_cnt;
    logic       a_frame_done, a_err, a_busy;

    logic       b_sel_fb, b_out_sel, b_out_en;
    logic [3:0] b_out_cnt;
    logic       b_frame_done, b_err, b_busy;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    sdf_stage_ctrl #(.N(16), .S(16), .LAT(1)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_in  (enable_in),
        .sel_fb     (a_sel_fb),
        .out_sel    (a_out_sel),
        .out_en     (a_out_en),
        .out_cnt    (a_out_cnt),
        .frame_done (a_frame_done),
        .err        (a_err),
        .busy       (a_busy)
    );

    sdf_stage_ctrl #(.N(16), .S(2), .LAT(3)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_in  (enable_in),
        .sel_fb     (b_sel_fb),
        .out_sel    (b_out_sel),
        .out_en     (b_out_en),
        .out_cnt    (b_out_cnt),
        .frame_done (b_frame_done),
        .err        (b_err),
        .busy       (b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic ck(input string tag, input int c,
                      input logic [31:0] obs, input int exp);
        total++;
        assert (obs === 32'(exp)) passed++;
        else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                   tag, c, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic single_frame();
        for (int c = 0; c < 30; c++) begin
            enable_in = (c < 16);
            #3;
            ck("a_sel_fb", c, a_sel_fb, int'(c >= 8 && c < 16));
            ck("a_out_sel", c, a_out_sel, int'(c >= 9 && c <= 16));
            ck("a_out_en", c, a_out_en, int'(c >= 9 && c <= 24));
            ck("a_out_cnt", c, a_out_cnt,
               (c >= 9 && c <= 24) ? c - 9 : 0);
            ck("a_frame_done", c, a_frame_done, int'(c == 24));
            ck("a_busy", c, a_busy, int'(c >= 1 && c <= 25));
            ck("a_err", c, a_err, 0);
            ck("b_sel_fb", c, b_sel_fb, int'(c < 16 && c % 2 == 1));
            ck("b_out_sel", c, b_out_sel,
               int'(c >= 4 && c <= 18 && c % 2 == 0));
            ck("b_out_en", c, b_out_en, int'(c >= 4 && c <= 19));
            ck("b_out_cnt", c, b_out_cnt,
               (c >= 4 && c <= 19) ? c - 4 : 0);
            ck("b_frame_done", c, b_frame_done, int'(c == 19));
            ck("b_busy", c, b_busy, int'(c >= 1 && c <= 20));
            ck("b_err", c, b_err, 0);
            next_cyc();
        end
    endtask

    task automatic back_to_back();
        for (int c = 0; c < 46; c++) begin
            enable_in = (c < 32);
            #3;
            ck("b2b_sel_fb", c, a_sel_fb,
               int'(c < 32 && (c % 16) >= 8));
            ck("b2b_out_sel", c, a_out_sel,
               int'((c >= 9 && c <= 16) || (c >= 25 && c <= 32)));
            ck("b2b_out_en", c, a_out_en, int'(c >= 9 && c <= 40));
            ck("b2b_out_cnt", c, a_out_cnt,
               (c >= 9 && c <= 40) ? (c - 9) % 16 : 0);
            ck("b2b_frame_done", c, a_frame_done,
               int'(c == 24 || c == 40));
            ck("b2b_busy", c, a_busy, int'(c >= 1 && c <= 41));
            ck("b2b_err", c, a_err, 0);
            next_cyc();
        end
    endtask

    task automatic abort_frame();
        for (int c = 0; c < 13; c++) begin
            enable_in = (c < 5);
            #3;
            ck("ab_err", c, a_err, int'(c == 5));
            ck("ab_out_en", c, a_out_en, 0);
            ck("ab_frame_done", c, a_frame_done, 0);
            ck("ab_busy", c, a_busy, int'(c >= 1 && c <= 5));
            next_cyc();
        end
    endtask

    task automatic reset_mid_run();
        for (int c = 0; c < 12; c++) begin
            enable_in = 1'b1;
            #3;
            ck("rm_out_en", c, a_out_en, int'(c >= 9));
            ck("rm_out_cnt", c, a_out_cnt, (c >= 9) ? c - 9 : 0);
            ck("rm_busy", c, a_busy, int'(c >= 1));
            next_cyc();
        end
        rst_n = 1'b0;
        #2;
        ck("rst_sel_fb", 12, a_sel_fb, 0);
        ck("rst_out_sel", 12, a_out_sel, 0);
        ck("rst_out_en", 12, a_out_en, 0);
        ck("rst_out_cnt", 12, a_out_cnt, 0);
        ck("rst_frame_done", 12, a_frame_done, 0);
        ck("rst_err", 12, a_err, 0);
        ck("rst_busy", 12, a_busy, 0);
        ck("rst_b_out_en", 12, b_out_en, 0);
        ck("rst_b_busy", 12, b_busy, 0);
        next_cyc();
        enable_in = 1'b0;
        next_cyc();
        next_cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        enable_in = 1'b0;
        #2;
        ck("por_out_en", -1, a_out_en, 0);
        ck("por_out_cnt", -1, a_out_cnt, 0);
        ck("por_busy", -1, a_busy, 0);
        ck("por_out_sel", -1, a_out_sel, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        single_frame();
        back_to_back();
        abort_frame();
        repeat (3) next_cyc();
        reset_mid_run();
        single_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 SHALL have parameter N, default 64: FFT points per frame; power of 2, at least 4.
REQ-002 SHALL have parameter S, default 64: span of the controlled stage; power of 2, 2..N.
REQ-003 SHALL have parameter LAT, default 1: butterfly latency in cycles; at least 1.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port enable_in, input, 1: input sample valid; high contiguously for whole frames.
REQ-007 SHALL have port sel_fb, output, 1: delay-line input mux select; 1 selects butterfly b, 0 selects the input sample.
REQ-008 SHALL have port out_sel, output, 1: output mux select; 1 selects butterfly a, 0 selects the delay line.
REQ-009 SHALL have port out_en, output, 1: stage output valid.
REQ-010 SHALL have port out_cnt, output, clog2(N): index of the current output sample.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse on the last output of a frame.
REQ-012 SHALL have port err, output, 1: one-cycle pulse when a frame is aborted.
REQ-013 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-014 SHALL have port tw_addr, output, clog2(N)-1: twiddle ROM address; present only under the macro in REQ-027.

Function
REQ-015 SHALL keep in_cnt (clog2(N) bits): increments each enable_in cycle, wraps N-1 to 0, and clears when enable_in is low.
REQ-016 SHALL drive sel_fb = in_cnt[clog2(S)-1] while enable_in is high, and 0 otherwise; sel_fb is combinational from registered in_cnt.
REQ-017 SHALL drive out_sel = sel_fb delayed by exactly LAT cycles.
REQ-018 SHALL implement FSM states and transitions:
- IDLE -> FILL on enable_in.
- FILL -> RUN on the first cycle with sel_fb=1.
- RUN -> FLUSH when enable_in falls with in_cnt==0 (whole frame).
- RUN or FILL -> IDLE with an err pulse when enable_in falls with in_cnt!=0.
- FLUSH -> IDLE after S/2+LAT cycles.
- FLUSH -> FILL on enable_in, with out_en continuing without a gap.
REQ-019 SHALL raise out_en LAT cycles after the first sel_fb=1 of a frame (latency S/2+LAT from the first input sample) and hold it high for exactly N cycles per frame.
REQ-020 SHALL count out_cnt 0..N-1 while out_en is high, wrap to 0 on back-to-back frames, and hold 0 when out_en is low.
REQ-021 SHALL pulse frame_done in the same cycle as out_en && out_cnt==N-1.
REQ-022 SHALL drop out_en on the cycle after an abort and never pulse frame_done for an aborted frame.
REQ-023 SHALL give rst_n priority over every event, including while FLUSH is in progress.

Reset
REQ-024 SHALL set all of the following to 0 on rst_n low, asynchronously: sel_fb, out_sel, out_en, out_cnt, frame_done, err, busy, tw_addr, in_cnt, and the delay pipe; SHALL set the state to IDLE.
REQ-025 SHALL release from reset synchronously to clk; the first sample is accepted on the first edge with rst_n high.

Configuration
REQ-026 SHALL have a build without twiddle generation as the default.
REQ-027 SHALL, when macro SDF_CTRL_TWIDDLE_EN is defined:
- include tw_addr.
- drive tw_addr = (out_cnt mod S/2) * (N/S) on cycles where out_sel==0 && out_en.
- drive tw_addr = 0 on all other cycles.
REQ-028 SHALL, when SDF_CTRL_TWIDDLE_EN is undefined, omit the tw_addr port and all of its logic.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, FILL, RUN, FLUSH) and the log2 width constants in package sdf_pkg, shared with the datapath.
REQ-030 SHALL realise the LAT-cycle delay of sel_fb and enable in sub-module sdf_pipe_dly, with parameters DEPTH and WIDTH and a reset register chain.

Verification
REQ-031 SHALL cover single frame (N=S=16, LAT=1, enable_in high cycles 0-15): sel_fb low 0-7 and high 8-15; out_en high 9-24; frame_done at 24; busy low from 26.
REQ-032 SHALL cover back-to-back frames (enable_in high 32 cycles): out_en high 9-40 with no gap; frame_done at 24 and 40; out_cnt wraps 15->0.
REQ-033 SHALL cover abort (enable_in high only cycles 0-4): err pulse at cycle 5; out_en never high; state IDLE.
REQ-034 SHALL cover reset mid-RUN (rst_n low at cycle 12): all outputs 0 immediately, before the next edge; a new frame after release behaves as in REQ-031.
REQ-035 SHALL cover twiddle with the macro defined (N=16, S=8): tw_addr sequence 0,2,4,6 on each delay-line output group; 0 elsewhere.
REQ-036 SHALL cover N=16, S=2, LAT=3: sel_fb toggles every cycle; out_en rises at cycle 4.
